// File: rtl/mem_pkg.sv
// Shared memory-port definitions: requester indices, function/type codes and
// the arbiter state encoding.
package mem_pkg;

    localparam int REQ_IMEM = 0;
    localparam int REQ_DMEM = 1;
    localparam int REQ_HTIF = 2;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    // Access types travel through the arbiter untouched.
    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_D  = 3'd4;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;
    localparam logic [2:0] MT_WU = 3'd7;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational priority select: htif > dmem > imem, unless the starvation
// guard forces imem to the front.
import mem_pkg::*;

module mem_arb_sel (
    input  logic [2:0] valid,
    input  logic       force_imem,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (valid[REQ_IMEM] && force_imem) begin
            grant[REQ_IMEM] = 1'b1;
        end else if (valid[REQ_HTIF]) begin
            grant[REQ_HTIF] = 1'b1;
        end else if (valid[REQ_DMEM]) begin
            grant[REQ_DMEM] = 1'b1;
        end else if (valid[REQ_IMEM]) begin
            grant[REQ_IMEM] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between imem, dmem and htif with a single outstanding
// transaction; responses are steered back to the requester that owns it.
import mem_pkg::*;

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      rq_valid,
    output logic [2:0]      rq_ready,
    input  logic [3*AW-1:0] rq_addr,
    input  logic [3*DW-1:0] rq_data,
    input  logic [2:0]      rq_fcn,
    input  logic [8:0]      rq_typ,
    output logic [2:0]      rs_valid,
    output logic [DW-1:0]   rs_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic [DW-1:0]   mem_req_data,
    output logic            mem_req_fcn,
    output logic [2:0]      mem_req_typ,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_resp_data,
    output logic            busy
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    arb_state_e    state;
    logic [2:0]    owner;
    logic [SW-1:0] starve_cnt;
    logic [2:0]    sel_valid;
    logic [2:0]    grant;
    logic          idle;
    logic          force_imem;
    logic          accept;

    // Gating with rst_n keeps every request-side output low while reset is held.
    assign idle       = rst_n && (state == ARB_IDLE);
    assign sel_valid  = rq_valid & {3{idle}};
    assign force_imem = (starve_cnt == SW'(STARVE_LIM));

    mem_arb_sel u_sel (
        .valid      (sel_valid),
        .force_imem (force_imem),
        .grant      (grant)
    );

    assign mem_req_valid = |sel_valid;
    assign rq_ready      = grant & {3{mem_req_ready}};
    assign accept        = mem_req_valid && mem_req_ready;
    assign busy          = (state == ARB_WAIT);

    always_comb begin
        mem_req_addr = '0;
        mem_req_data = '0;
        mem_req_fcn  = M_XRD;
        mem_req_typ  = MT_X;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                mem_req_addr = rq_addr[i*AW +: AW];
                mem_req_data = rq_data[i*DW +: DW];
                mem_req_fcn  = rq_fcn[i];
                mem_req_typ  = rq_typ[i*3 +: 3];
            end
        end
    end

    // A response outside WAIT is a protocol error and is silently dropped.
    always_comb begin
        rs_valid = '0;
        rs_data  = '0;
        if (state == ARB_WAIT && mem_resp_valid) begin
            rs_valid = owner;
            rs_data  = mem_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (!rq_valid[REQ_IMEM] || (grant[REQ_IMEM] && mem_req_ready)) begin
                        starve_cnt <= '0;
                    end else if (!grant[REQ_IMEM] && !force_imem) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                    if (accept) begin
                        state <= ARB_WAIT;
                        owner <= grant;
                    end
                end
                ARB_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter: a reference model predicts
// grants each IDLE cycle and a scoreboard matches every response to its owner.
import mem_pkg::*;

module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      rq_valid = '0;
    logic [2:0]      rq_ready;
    logic [3*AW-1:0] rq_addr = '0;
    logic [3*DW-1:0] rq_data = '0;
    logic [2:0]      rq_fcn = '0;
    logic [8:0]      rq_typ = '0;
    logic [2:0]      rs_valid;
    logic [DW-1:0]   rs_data;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data;
    logic            mem_req_fcn;
    logic [2:0]      mem_req_typ;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_resp_data;
    logic            busy;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rq_valid       (rq_valid),
        .rq_ready       (rq_ready),
        .rq_addr        (rq_addr),
        .rq_data        (rq_data),
        .rq_fcn         (rq_fcn),
        .rq_typ         (rq_typ),
        .rs_valid       (rs_valid),
        .rs_data        (rs_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_fcn    (mem_req_fcn),
        .mem_req_typ    (mem_req_typ),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model and scoreboard state
    bit              m_busy = 1'b0;
    int              m_starve = 0;
    logic [2:0]      fired = '0;
    bit              mem_fire = 1'b0;
    logic [2:0]      own_q[$];
    logic [DW-1:0]   exp_q[$];
    logic [2:0]      grant_log[$];

    // Memory model controls
    int              lat_min = 0;
    int              lat_max = 0;
    bit              use_fixed = 1'b0;
    logic [DW-1:0]   fixed_data = '0;
    bit              orphan_req = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner from the written priority rules, with imem pulled to the front once
    // it has been passed over LIM times in a row.
    function automatic logic [2:0] ref_pick(input logic [2:0] v, input int starve);
        if (v[REQ_IMEM] && starve >= LIM) return 3'b001;
        if (v[REQ_HTIF]) return 3'b100;
        if (v[REQ_DMEM]) return 3'b010;
        if (v[REQ_IMEM]) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [67:0] req_fields(input logic [2:0] w);
        int i;
        i = w[2] ? 2 : (w[1] ? 1 : 0);
        return {rq_addr[i*AW +: AW], rq_data[i*DW +: DW], rq_fcn[i], rq_typ[i*3 +: 3]};
    endfunction

    // Monitor: samples on the falling edge, compares and advances the model.
    always @(negedge clk) begin
        logic [2:0]    w;
        logic [2:0]    o;
        logic [DW-1:0] d;
        if (!rst_n) begin
            chk("reset_outputs", {rq_ready, rs_valid, rs_data, mem_req_valid, mem_req_addr,
                                  mem_req_data, mem_req_fcn, mem_req_typ, busy}, '0);
            m_busy = 1'b0;
            m_starve = 0;
            fired = '0;
            mem_fire = 1'b0;
            own_q.delete();
            exp_q.delete();
        end else begin
            fired = '0;
            mem_fire = 1'b0;
            chk("busy", busy, m_busy);
            if (!m_busy) begin
                w = ref_pick(rq_valid, m_starve);
                chk("mem_req_valid", mem_req_valid, |rq_valid);
                chk("rq_ready", rq_ready, mem_req_ready ? w : 3'b000);
                if (|w) chk("mem_req_fields",
                            {mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ}, req_fields(w));
                if (mem_resp_valid) chk("orphan_drop", rs_valid, 3'b000);
                else chk("rs_idle", rs_valid, 3'b000);
                if (!rq_valid[REQ_IMEM]) m_starve = 0;
                else if (w[REQ_IMEM]) begin
                    if (mem_req_ready) m_starve = 0;
                end else if (m_starve < LIM) m_starve++;
                if (|rq_valid && mem_req_ready) begin
                    m_busy = 1'b1;
                    own_q.push_back(w);
                    grant_log.push_back(w);
                    fired = w;
                    mem_fire = 1'b1;
                end
            end else begin
                chk("wait_quiet", {mem_req_valid, rq_ready}, 4'b0);
                if (rs_valid != 3'b000) begin
                    if (own_q.size() == 0 || exp_q.size() == 0) begin
                        chk("rs_unexpected", rs_valid, 3'b000);
                    end else begin
                        o = own_q.pop_front();
                        d = exp_q.pop_front();
                        chk("rs_valid", rs_valid, o);
                        chk("rs_data", rs_data, d);
                    end
                end else if (mem_resp_valid) begin
                    chk("rs_missing", rs_valid, own_q.size() > 0 ? own_q[0] : 3'b111);
                end
                if (mem_resp_valid) m_busy = 1'b0;
            end
        end
    end

    // Memory responder: one response per accepted request after a short delay.
    initial begin
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt = 0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (mem_fire) begin
                    pend = 1'b1;
                    cnt = $urandom_range(lat_min, lat_max);
                end
                if (pend) begin
                    if (cnt == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data = use_fixed ? fixed_data : DW'($urandom);
                        exp_q.push_back(mem_resp_data);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (orphan_req) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data = 32'hBAD0_BAD0;
                end
            end
        end
    end

    // Driver tasks
    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic f, input logic [2:0] t);
        rq_valid[i] = 1'b1;
        rq_addr[i*AW +: AW] = a;
        rq_data[i*DW +: DW] = d;
        rq_fcn[i] = f;
        rq_typ[i*3 +: 3] = t;
    endtask

    task automatic set_rand_req(input int i);
        set_req(i, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    endtask

    task automatic wait_accept(input int i, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (fired[i]) begin
                rq_valid[i] = 1'b0;
                return;
            end
        end
        chk("timeout_accept", 1'b0, 1'b1);
    endtask

    task automatic wait_all(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            rq_valid = rq_valid & ~fired;
            if (rq_valid == 3'b000) return;
        end
        chk("timeout_all", rq_valid, 3'b000);
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #2;
            if (!m_busy) return;
        end
        chk("timeout_idle", m_busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int n_dmem;
        bit got;
        logic [2:0] t2_exp[3];

        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_dmem;
        bit got;
        logic [2:0] t2_exp [3];
        t2_exp[0] = 3'b100;
        t2_exp[1] = 3'b010;
        t2_exp[2] = 3'b001;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: single imem read
        use_fixed = 1'b1;
        fixed_data = 32'hDEAD_BEEF;
        lat_min = 0;
        lat_max = 0;
        mem_req_ready = 1'b1;
        set_req(REQ_IMEM, 32'h100, '0, M_XRD, MT_W);
        wait_accept(REQ_IMEM, 10, cyc);
        wait_idle(10);

        // T2: all three valid together
        grant_log.delete();
        set_rand_req(0);
        set_rand_req(1);
        set_rand_req(2);
        wait_all(40);
        wait_idle(10);
        chk("t2_grant_count", 32'(grant_log.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < grant_log.size()) chk("t2_order", grant_log[k], t2_exp[k]);
        end

        // T3: dmem store
        fixed_data = 32'h0000_5A5A;
        set_req(REQ_DMEM, 32'h2000, 32'h1234_5678, M_XWR, MT_W);
        wait_accept(REQ_DMEM, 10, cyc);
        wait_idle(10);

        // T4: imem starved by a continuous dmem stream
        use_fixed = 1'b0;
        n_dmem = 0;
        got = 1'b0;
        set_rand_req(REQ_IMEM);
        set_rand_req(REQ_DMEM);
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #1;
            if (fired[REQ_IMEM]) begin
                got = 1'b1;
                rq_valid[REQ_IMEM] = 1'b0;
            end
            if (fired[REQ_DMEM]) begin
                n_dmem++;
                set_rand_req(REQ_DMEM);
            end
        end
        rq_valid[REQ_DMEM] = 1'b0;
        chk("t4_imem_granted", got, 1'b1);
        chk("t4_dmem_before_imem", 32'(n_dmem), 32'(LIM));
        wait_idle(10);

        // T5: memory back-pressure
        mem_req_ready = 1'b0;
        set_rand_req(REQ_DMEM);
        repeat (5) @(posedge clk);
        #1 mem_req_ready = 1'b1;
        wait_accept(REQ_DMEM, 5, cyc);
        chk("t5_first_ready", 32'(cyc), 32'd1);
        wait_idle(10);

        // T6: reset in WAIT, then an orphan response
        lat_min = 3;
        lat_max = 3;
        set_rand_req(REQ_IMEM);
        wait_accept(REQ_IMEM, 10, cyc);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        set_rand_req(REQ_DMEM);
        repeat (2) @(posedge clk);
        #3;
        rq_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        #1 orphan_req = 1'b1;
        @(negedge clk);
        #1 orphan_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Random traffic
        lat_min = 0;
        lat_max = 3;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            rq_valid = rq_valid & ~fired;
            for (int i = 0; i < 3; i++) begin
                if (!rq_valid[i] && $urandom_range(0, 2) == 0) set_rand_req(i);
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
        end
        mem_req_ready = 1'b1;
        wait_all(100);
        wait_idle(10);
        chk("drain_scoreboard", 32'(own_q.size() + exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
